// File: rtl/bcd_game_timer.sv
// N-digit packed-BCD game timer: counts ticks down to zero or up to a limit.
// Also provides saturating bonus injection, a low-time warning and terminal-count flags.
module bcd_game_timer #(
    parameter int                  DIGITS      = 3,
    parameter logic [4*DIGITS-1:0] LOAD_VALUE  = 12'h120,
    parameter logic [4*DIGITS-1:0] UP_LIMIT    = 12'h999,
    parameter logic [4*DIGITS-1:0] BONUS_VALUE = 12'h015,
    parameter logic [4*DIGITS-1:0] WARN_VALUE  = 12'h010
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  loadN,
    input  logic                  ena,
    input  logic                  ena_cnt,
    input  logic                  countDownMode,
    input  logic                  bonus_pulse,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  tc_pulse,
    output logic                  warning
);

    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] all_nines();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'h9;
        end
        return r;
    endfunction

    localparam logic [W-1:0] ALL_NINES = all_nines();
    localparam logic [W-1:0] ONE       = {{(W-1){1'b0}}, 1'b1};

    // Digit-serial ripple add with decimal adjust; MSB of the result is the carry out.
    function automatic logic [W:0] bcd_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] sum;
        logic         carry;
        logic [4:0]   d;
        sum   = '0;
        carry = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, carry};
            if (d > 5'd9) begin
                d     = d - 5'd10;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            sum[4*i +: 4] = d[3:0];
        end
        return {carry, sum};
    endfunction

    // Digit-serial ripple subtract; a negative digit shows up as bit 4 and is
    // pulled back into 0..9 by adding ten. MSB of the result is the borrow out.
    function automatic logic [W:0] bcd_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] diff;
        logic         borrow;
        logic [4:0]   d;
        diff   = '0;
        borrow = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            d = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0000, borrow};
            if (d[4]) begin
                d      = d + 5'd10;
                borrow = 1'b1;
            end else begin
                borrow = 1'b0;
            end
            diff[4*i +: 4] = d[3:0];
        end
        return {borrow, diff};
    endfunction

    function automatic logic is_terminal(input logic [W-1:0] value, input logic down);
        return down ? (value == '0) : (value >= UP_LIMIT);
    endfunction

    logic [W:0]   bonus_add;
    logic [W:0]   bonus_sub;
    logic [W:0]   tick_inc;
    logic [W:0]   tick_dec;
    logic [W-1:0] next_count;
    logic         stepped;

    assign bonus_add = bcd_add(count, BONUS_VALUE);
    assign bonus_sub = bcd_sub(count, BONUS_VALUE);
    assign tick_inc  = bcd_add(count, ONE);
    assign tick_dec  = bcd_sub(count, ONE);

    assign tc      = is_terminal(count, countDownMode);
    assign warning = countDownMode && (count != '0) && (count <= WARN_VALUE);

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        next_count = count;
        stepped    = 1'b0;
        if (!loadN) begin
            next_count = LOAD_VALUE;
        end else if (ena && !tc) begin
            if (bonus_pulse) begin
                stepped = 1'b1;
                if (countDownMode) begin
                    next_count = bonus_add[W] ? ALL_NINES : bonus_add[W-1:0];
                end else begin
                    next_count = bonus_sub[W] ? '0 : bonus_sub[W-1:0];
                end
            end else if (ena_cnt) begin
                stepped = 1'b1;
                if (countDownMode) begin
                    next_count = tick_dec[W] ? '0 : tick_dec[W-1:0];
                end else begin
                    next_count = tick_inc[W] ? ALL_NINES : tick_inc[W-1:0];
                end
            end
        end
    end

    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count    <= LOAD_VALUE;
            tc_pulse <= 1'b0;
        end else begin
            count    <= next_count;
            tc_pulse <= stepped && is_terminal(next_count, countDownMode);
        end
    end

endmodule

// File: tb/tb_bcd_game_timer.sv
// Self-checking bench for bcd_game_timer: a constant vector table plus an
// integer-domain reference model driving a scoreboard queue.
module tb_bcd_game_timer;

    localparam int LOAD_DEC  = 120;
    localparam int UP_DEC    = 999;
    localparam int BONUS_DEC = 15;
    localparam int WARN_DEC  = 10;

    logic        clk = 1'b0;
    logic        resetN;
    logic        loadN;
    logic        ena;
    logic        ena_cnt;
    logic        countDownMode;
    logic        bonus_pulse;
    logic [11:0] count;
    logic        tc;
    logic        tc_pulse;
    logic        warning;

    always #5 clk = ~clk;

    bcd_game_timer #(
        .DIGITS      (3),
        .LOAD_VALUE  (12'h120),
        .UP_LIMIT    (12'h999),
        .BONUS_VALUE (12'h015),
        .WARN_VALUE  (12'h010)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .loadN         (loadN),
        .ena           (ena),
        .ena_cnt       (ena_cnt),
        .countDownMode (countDownMode),
        .bonus_pulse   (bonus_pulse),
        .count         (count),
        .tc            (tc),
        .tc_pulse      (tc_pulse),
        .warning       (warning)
    );

    typedef struct {
        logic [11:0] count;
        logic        tc;
        logic        pulse;
        logic        warn;
        string       name;
    } exp_t;

    typedef struct {
        logic ld;
        logic en;
        logic tk;
        logic md;
        logic bn;
        exp_t exp;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   model_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[3:0]  = 4'(v % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[11:8] = 4'((v / 100) % 10);
        return r;
    endfunction

    function automatic bit model_term(input int v, input logic md);
        return md ? (v == 0) : (v >= UP_DEC);
    endfunction

    function automatic vec_t mkv(input logic ld, input logic en, input logic tk, input logic md,
                                 input logic bn, input logic [11:0] c, input logic t,
                                 input logic p, input logic w, input string n);
        vec_t v;
        v.ld = ld; v.en = en; v.tk = tk; v.md = md; v.bn = bn;
        v.exp.count = c; v.exp.tc = t; v.exp.pulse = p; v.exp.warn = w; v.exp.name = n;
        return v;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic drive_and_check(input logic ld, input logic en, input logic tk,
                                   input logic md, input logic bn, input exp_t e);
        exp_t got;
        @(negedge clk);
        loadN = ld; ena = en; ena_cnt = tk; countDownMode = md; bonus_pulse = bn;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({got.name, " count"}, 32'(count), 32'(got.count));
        check({got.name, " tc"}, 32'(tc), 32'(got.tc));
        check({got.name, " tc_pulse"}, 32'(tc_pulse), 32'(got.pulse));
        check({got.name, " warning"}, 32'(warning), 32'(got.warn));
        for (int i = 0; i < 3; i++) begin
            check({got.name, " digit_legal"}, 32'(count[4*i +: 4] <= 4'd9), 32'd1);
        end
        loadN = 1'b1; ena = 1'b1; ena_cnt = 1'b0; bonus_pulse = 1'b0;
    endtask

    task automatic apply(input logic ld, input logic en, input logic tk, input logic md,
                         input logic bn, input string name);
        exp_t e;
        bit   stepped;
        stepped = 1'b0;
        if (!ld) begin
            model_v = LOAD_DEC;
        end else if (en && !model_term(model_v, md)) begin
            if (bn) begin
                stepped = 1'b1;
                if (md) model_v = (model_v + BONUS_DEC > UP_DEC) ? UP_DEC : model_v + BONUS_DEC;
                else    model_v = (model_v < BONUS_DEC) ? 0 : model_v - BONUS_DEC;
            end else if (tk) begin
                stepped = 1'b1;
                model_v = md ? model_v - 1 : model_v + 1;
            end
        end
        e.count = to_bcd(model_v);
        e.tc    = model_term(model_v, md);
        e.pulse = stepped && model_term(model_v, md);
        e.warn  = md && (model_v != 0) && (model_v <= WARN_DEC);
        e.name  = name;
        drive_and_check(ld, en, tk, md, bn, e);
    endtask

    task automatic goto_value(input int target);
        while (model_v != target) begin
            if (model_v < target) apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "goto_up");
            else                  apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "goto_down");
        end
    endtask

    // Mode change without a clock edge: tc and warning must follow immediately.
    task automatic set_mode(input logic md, input string name);
        @(negedge clk);
        countDownMode = md;
        #1;
        check({name, " tc"}, 32'(tc), 32'(model_term(model_v, md)));
        check({name, " warning"}, 32'(warning),
              32'(md && (model_v != 0) && (model_v <= WARN_DEC)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        bit   seen_119;
        bit   seen_100;
        bit   seen_099;

        resetN = 1'b0; loadN = 1'b1; ena = 1'b1; ena_cnt = 1'b0;
        countDownMode = 1'b1; bonus_pulse = 1'b0;
        repeat (2) @(negedge clk);
        check("reset count", 32'(count), 32'h120);
        check("reset tc", 32'(tc), 32'd0);
        check("reset tc_pulse", 32'(tc_pulse), 32'd0);
        check("reset warning", 32'(warning), 32'd0);
        resetN = 1'b1;
        model_v = LOAD_DEC;

        //                ld    en    tk    md    bn    count    tc    p     w
        vecs[0] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h120, 1'b0, 1'b0, 1'b0, "tbl_load_ena_low");
        vecs[1] = mkv(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h119, 1'b0, 1'b0, 1'b0, "tbl_tick_down");
        vecs[2] = mkv(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h119, 1'b0, 1'b0, 1'b0, "tbl_ena_low_hold");
        vecs[3] = mkv(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 12'h134, 1'b0, 1'b0, 1'b0, "tbl_bonus_down");
        vecs[4] = mkv(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'h149, 1'b0, 1'b0, 1'b0, "tbl_bonus_tick");
        vecs[5] = mkv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h150, 1'b0, 1'b0, 1'b0, "tbl_tick_up");
        vecs[6] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h135, 1'b0, 1'b0, 1'b0, "tbl_bonus_up");
        vecs[7] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h135, 1'b0, 1'b0, 1'b0, "tbl_bonus_ena_low");
        vecs[8] = mkv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h120, 1'b0, 1'b0, 1'b0, "tbl_load_beats_tick");
        vecs[9] = mkv(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h119, 1'b0, 1'b0, 1'b0, "tbl_tick_down_again");
        for (int i = 0; i < 10; i++) begin
            drive_and_check(vecs[i].ld, vecs[i].en, vecs[i].tk, vecs[i].md, vecs[i].bn, vecs[i].exp);
        end
        model_v = 119;

        // 21 down ticks from 0x120 with full borrow through the tens and hundreds.
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "reload");
        seen_119 = 1'b0; seen_100 = 1'b0; seen_099 = 1'b0;
        for (int i = 0; i < 21; i++) begin
            apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "down_run");
            if (count == 12'h119) seen_119 = 1'b1;
            if (count == 12'h100) seen_100 = 1'b1;
            if (count == 12'h099) seen_099 = 1'b1;
        end
        check("down_run saw 119", 32'(seen_119), 32'd1);
        check("down_run saw 100", 32'(seen_100), 32'd1);
        check("down_run saw 099", 32'(seen_099), 32'd1);
        check("down_run final", 32'(count), 32'h099);

        // Asynchronous reset mid-count, sampled before any clock edge.
        goto_value(57);
        @(negedge clk);
        #2;
        resetN = 1'b0;
        #1;
        check("async_reset count", 32'(count), 32'h120);
        check("async_reset tc_pulse", 32'(tc_pulse), 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        model_v = LOAD_DEC;

        // Reaching zero, the frozen terminal state, and load out of it.
        goto_value(3);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "to_zero_1");
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "to_zero_2");
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "to_zero_3");
        check("zero count", 32'(count), 32'h000);
        check("zero tc_pulse", 32'(tc_pulse), 32'd1);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "zero_tick_hold");
        check("zero pulse once", 32'(tc_pulse), 32'd0);
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "zero_bonus_hold");
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "zero_load_ena_low");
        check("zero_load count", 32'(count), 32'h120);

        // Bonus in down mode, including saturation at all nines.
        goto_value(50);
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "bonus_050");
        check("bonus_050 result", 32'(count), 32'h065);
        goto_value(50);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "bonus_tick_050");
        check("bonus_tick_050 result", 32'(count), 32'h065);
        goto_value(990);
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "bonus_sat");
        check("bonus_sat result", 32'(count), 32'h999);

        // Up mode: carry, bonus floor at zero, limit and mode switch.
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "up_reload");
        goto_value(199);
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "up_carry");
        check("up_carry result", 32'(count), 32'h200);
        goto_value(10);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "up_bonus_floor");
        check("up_bonus_floor count", 32'(count), 32'h000);
        check("up_bonus_floor tc", 32'(tc), 32'd0);
        goto_value(998);
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "up_limit");
        check("up_limit count", 32'(count), 32'h999);
        check("up_limit tc_pulse", 32'(tc_pulse), 32'd1);
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "up_limit_hold");
        set_mode(1'b1, "switch_down");
        check("switch_down tc", 32'(tc), 32'd0);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "switch_down_tick");
        check("switch_down_tick count", 32'(count), 32'h998);

        // Warning threshold edges.
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "warn_reload");
        goto_value(11);
        check("warn_011", 32'(warning), 32'd0);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "warn_tick_010");
        check("warn_010", 32'(warning), 32'd1);
        goto_value(1);
        check("warn_001", 32'(warning), 32'd1);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "warn_tick_000");
        check("warn_000", 32'(warning), 32'd0);
        goto_value(5);
        check("warn_up_005", 32'(warning), 32'd0);
        set_mode(1'b1, "warn_down_005");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
